// File: rtl/snoop_bus_controller_if.sv
// Bus-side signal bundle for the snooping bus controller.
// Carries requester commands, snoop responses, memory port and completion.
// master = requesters/snoopers/memory side, slave = controller side.
interface snoop_bus_controller_if #(
  parameter int N_PROC = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [N_PROC-1:0]        req;
  logic [2*N_PROC-1:0]      req_op;
  logic [ADDR_W*N_PROC-1:0] req_addr;
  logic [DATA_W*N_PROC-1:0] req_data;
  logic [N_PROC-1:0]        gnt;
  logic [N_PROC-1:0]        done;
  logic                     bus_valid;
  logic [1:0]               bus_op;
  logic [ADDR_W-1:0]        bus_addr;
  logic [1:0]               bus_src;
  logic [N_PROC-1:0]        snoop_abort;
  logic [N_PROC-1:0]        snoop_shared;
  logic [DATA_W*N_PROC-1:0] snoop_wb_data;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_we;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic [DATA_W-1:0]        rsp_data;
  logic                     rsp_shared;

  modport master (
    output req, req_op, req_addr, req_data, snoop_abort, snoop_shared, snoop_wb_data, mem_rdata,
    input  gnt, done, bus_valid, bus_op, bus_addr, bus_src, mem_addr, mem_we, mem_wdata,
           rsp_data, rsp_shared
  );

  modport slave (
    input  req, req_op, req_addr, req_data, snoop_abort, snoop_shared, snoop_wb_data, mem_rdata,
    output gnt, done, bus_valid, bus_op, bus_addr, bus_src, mem_addr, mem_we, mem_wdata,
           rsp_data, rsp_shared
  );
endinterface

// File: rtl/snoop_bus_controller.sv
// Round-robin MESI shared-bus controller: snoop broadcast, write-back, memory fetch, response.
// Latency: done 2 cycles (WM/INV), 3 (abort or WB), 4 (clean RD) after the IDLE sample cycle.
// Backpressure: one transaction at a time; other requesters hold req until their done.
module snoop_bus_controller #(
  parameter int N_PROC = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic                   clock,
  input logic                   reset,
  snoop_bus_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SNOOP, WB, MEMR, MEMD, MEMW, RESP} state_t;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WM  = 2'd1;
  localparam logic [1:0] OP_INV = 2'd2;
  localparam logic [1:0] OP_WB  = 2'd3;

  state_t              state;
  logic [1:0]          src;
  logic [1:0]          op;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          rr_ptr;
  logic                shared_q;

  logic                any_req;
  logic [1:0]          pick;
  logic [2:0]          cand;
  logic [N_PROC-1:0]   pick_oh;
  logic [N_PROC-1:0]   own;
  logic [N_PROC-1:0]   abort_m;
  logic [N_PROC-1:0]   shared_m;
  logic [DATA_W-1:0]   wb_sel;
  logic                shared_now;

  // Round-robin pick: first requester at or after rr_ptr (descending loop so the nearest wins).
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    pick_oh = '0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'(N_PROC)) cand = cand - 3'(N_PROC);
      if (bus.req[cand[1:0]]) begin
        any_req = 1'b1;
        pick    = cand[1:0];
      end
    end
    pick_oh[pick] = 1'b1;
  end

  // Snoop response with the requester's own bits masked; lowest-index aborter supplies data.
  always_comb begin
    own       = '0;
    own[src]  = 1'b1;
    abort_m   = bus.snoop_abort & ~own;
    shared_m  = bus.snoop_shared & ~own;
    wb_sel    = '0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (abort_m[i]) wb_sel = bus.snoop_wb_data[DATA_W*i +: DATA_W];
    end
    shared_now = (op == OP_RD) && (|(abort_m | shared_m));
  end

  // Transaction FSM with all bus/memory/response outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      src            <= '0;
      op             <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      rr_ptr         <= '0;
      shared_q       <= 1'b0;
      bus.gnt        <= '0;
      bus.done       <= '0;
      bus.bus_valid  <= 1'b0;
      bus.bus_op     <= '0;
      bus.bus_addr   <= '0;
      bus.bus_src    <= '0;
      bus.mem_addr   <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= '0;
      bus.rsp_data   <= '0;
      bus.rsp_shared <= 1'b0;
    end else begin
      bus.bus_valid <= 1'b0;
      bus.done      <= '0;
      bus.mem_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            src           <= pick;
            op            <= bus.req_op[2*pick +: 2];
            addr_q        <= bus.req_addr[ADDR_W*pick +: ADDR_W];
            data_q        <= bus.req_data[DATA_W*pick +: DATA_W];
            bus.gnt       <= pick_oh;
            bus.bus_valid <= 1'b1;
            bus.bus_op    <= bus.req_op[2*pick +: 2];
            bus.bus_addr  <= bus.req_addr[ADDR_W*pick +: ADDR_W];
            bus.bus_src   <= pick;
            state         <= SNOOP;
          end
        end
        SNOOP: begin
          shared_q <= shared_now;
          if ((op == OP_RD || op == OP_WM) && (|abort_m)) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_q;
            bus.mem_wdata <= wb_sel;
            bus.rsp_data  <= wb_sel;
            state         <= WB;
          end else if (op == OP_RD) begin
            bus.mem_addr <= addr_q;
            state        <= MEMR;
          end else if (op == OP_WB) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_q;
            bus.mem_wdata <= data_q;
            state         <= MEMW;
          end else begin
            bus.done       <= bus.gnt;
            bus.rsp_shared <= shared_now;
            state          <= RESP;
          end
        end
        WB, MEMW: begin
          bus.done       <= bus.gnt;
          bus.rsp_shared <= shared_q;
          state          <= RESP;
        end
        MEMR: state <= MEMD;
        MEMD: begin
          bus.rsp_data   <= bus.mem_rdata;
          bus.done       <= bus.gnt;
          bus.rsp_shared <= shared_q;
          state          <= RESP;
        end
        RESP: begin
          bus.gnt        <= '0;
          bus.rsp_shared <= 1'b0;
          rr_ptr         <= (src == 2'(N_PROC - 1)) ? 2'd0 : src + 2'd1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snoop_bus_controller.sv
// Scoreboard bench for snoop_bus_controller: directed transactions push expected
// bus broadcasts, memory writes and responses; a negedge monitor pops and compares.
module tb_snoop_bus_controller;
  localparam int NP = 3;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clock;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  snoop_bus_controller_if #(.N_PROC(NP), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

  snoop_bus_controller #(.N_PROC(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  typedef struct { int src; bit chk_data; logic [7:0] data; logic shared; int cyc; } rsp_t;
  typedef struct { logic [1:0] op; logic [4:0] addr; int src; int cyc; } bev_t;
  typedef struct { logic [4:0] addr; logic [7:0] data; } wr_t;

  rsp_t rsp_q[$];
  bev_t bus_q[$];
  wr_t  wr_q[$];
  logic [7:0] mem [32];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: registered read, write on mem_we.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h40 + 8'(i);
    mem[5] = 8'h3C;
    mem[9] = 8'h00;
    bus_if.mem_rdata <= '0;
    forever begin
      @(posedge clock);
      bus_if.mem_rdata <= mem[bus_if.mem_addr];
      if (bus_if.mem_we) mem[bus_if.mem_addr] = bus_if.mem_wdata;
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh(int p);
    return 1 << p;
  endfunction

  // Monitor: compares every DUT output event against the head of its queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus_if.bus_valid) begin
        if (bus_q.size() == 0) chk("unexpected_bus_valid", 1, 0);
        else begin
          bev_t e;
          e = bus_q.pop_front();
          chk("bus_cycle", cyc, e.cyc);
          chk("bus_op", int'(bus_if.bus_op), int'(e.op));
          chk("bus_addr", int'(bus_if.bus_addr), int'(e.addr));
          chk("bus_src", int'(bus_if.bus_src), e.src);
          chk("bus_gnt", int'(bus_if.gnt), oh(e.src));
        end
      end
      if (|bus_if.done) begin
        if (rsp_q.size() == 0) chk("unexpected_done", int'(bus_if.done), 0);
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("done_cycle", cyc, r.cyc);
          chk("done_vec", int'(bus_if.done), oh(r.src));
          chk("done_gnt", int'(bus_if.gnt), oh(r.src));
          chk("rsp_shared", int'(bus_if.rsp_shared), int'(r.shared));
          if (r.chk_data) chk("rsp_data", int'(bus_if.rsp_data), int'(r.data));
        end
      end
      if (bus_if.mem_we) begin
        if (wr_q.size() == 0) chk("unexpected_mem_we", 1, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("mem_waddr", int'(bus_if.mem_addr), int'(w.addr));
          chk("mem_wdata", int'(bus_if.mem_wdata), int'(w.data));
        end
      end
    end
  end

  task automatic push_bus(logic [1:0] op, logic [4:0] a, int p, int c);
    bev_t e;
    e.op = op; e.addr = a; e.src = p; e.cyc = c;
    bus_q.push_back(e);
  endtask

  task automatic push_rsp(int p, bit cd, logic [7:0] d, logic s, int c);
    rsp_t r;
    r.src = p; r.chk_data = cd; r.data = d; r.shared = s; r.cyc = c;
    rsp_q.push_back(r);
  endtask

  task automatic push_wr(logic [4:0] a, logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic set_req(int p, logic [1:0] op, logic [4:0] a, logic [7:0] d);
    bus_if.req_op[2*p +: 2]    = op;
    bus_if.req_addr[AW*p +: AW] = a;
    bus_if.req_data[DW*p +: DW] = d;
    bus_if.req[p]              = 1'b1;
  endtask

  task automatic set_snoop(logic [2:0] ab, logic [2:0] sh, logic [23:0] wbd);
    bus_if.snoop_abort   = ab;
    bus_if.snoop_shared  = sh;
    bus_if.snoop_wb_data = wbd;
  endtask

  // Wait (bounded) for all expectations to be consumed, then settle with snoop inputs cleared.
  task automatic drain();
    int n = 0;
    while ((rsp_q.size() + bus_q.size() + wr_q.size()) != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", rsp_q.size() + bus_q.size() + wr_q.size(), 0);
    rsp_q.delete();
    bus_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clock);
    set_snoop(3'b000, 3'b000, 24'h0);
  endtask

  // One requester, one transaction; req dropped in the done cycle.
  task automatic single(int p, logic [1:0] op, logic [4:0] a, logic [7:0] d, int k,
                        bit cd, logic [7:0] ed, logic es);
    int c;
    @(negedge clock);
    c = cyc;
    set_req(p, op, a, d);
    push_bus(op, a, p, c + 1);
    push_rsp(p, cd, ed, es, c + k);
    repeat (k) @(negedge clock);
    bus_if.req[p] = 1'b0;
    drain();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_gnt"}, int'(bus_if.gnt), 0);
    chk({tag, "_done"}, int'(bus_if.done), 0);
    chk({tag, "_bus_valid"}, int'(bus_if.bus_valid), 0);
    chk({tag, "_bus_addr"}, int'(bus_if.bus_addr), 0);
    chk({tag, "_mem_we"}, int'(bus_if.mem_we), 0);
    chk({tag, "_mem_addr"}, int'(bus_if.mem_addr), 0);
    chk({tag, "_rsp_data"}, int'(bus_if.rsp_data), 0);
    chk({tag, "_rsp_shared"}, int'(bus_if.rsp_shared), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    reset = 1'b1;
    bus_if.req = '0;
    bus_if.req_op = '0;
    bus_if.req_addr = '0;
    bus_if.req_data = '0;
    set_snoop(3'b000, 3'b000, 24'h0);
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // P1 clean read miss of address 5.
    single(1, 2'd0, 5'd5, 8'h00, 4, 1'b1, 8'h3C, 1'b0);

    // P0 read of 9 with P2 aborting: write-back of A5, shared response.
    set_snoop(3'b100, 3'b000, {8'hA5, 8'h00, 8'h00});
    push_wr(5'd9, 8'hA5);
    single(0, 2'd0, 5'd9, 8'h00, 3, 1'b1, 8'hA5, 1'b1);
    // Memory now holds A5 at address 9.
    single(1, 2'd0, 5'd9, 8'h00, 4, 1'b1, 8'hA5, 1'b0);

    // Three simultaneous read misses from reset, all held: grant order 0,1,2,0.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    c = cyc;
    set_req(0, 2'd0, 5'd1, 8'h00);
    set_req(1, 2'd0, 5'd2, 8'h00);
    set_req(2, 2'd0, 5'd3, 8'h00);
    push_bus(2'd0, 5'd1, 0, c + 1);  push_rsp(0, 1'b1, 8'h41, 1'b0, c + 4);
    push_bus(2'd0, 5'd2, 1, c + 6);  push_rsp(1, 1'b1, 8'h42, 1'b0, c + 9);
    push_bus(2'd0, 5'd3, 2, c + 11); push_rsp(2, 1'b1, 8'h43, 1'b0, c + 14);
    push_bus(2'd0, 5'd1, 0, c + 16); push_rsp(0, 1'b1, 8'h41, 1'b0, c + 19);
    repeat (19) @(negedge clock);
    bus_if.req = '0;
    drain();

    // P2 invalidate of 3 with P0 shared and aborting: abort ignored.
    set_snoop(3'b001, 3'b001, {8'h00, 8'h00, 8'hBB});
    single(2, 2'd2, 5'd3, 8'h00, 2, 1'b0, 8'h00, 1'b0);

    // P1 write-back of 0x11 to address 7.
    push_wr(5'd7, 8'h11);
    single(1, 2'd3, 5'd7, 8'h11, 3, 1'b0, 8'h00, 1'b0);

    // P0 read of 7 with only its own abort/shared bits set: masked, plain memory read.
    set_snoop(3'b001, 3'b001, {8'h00, 8'h00, 8'hEE});
    single(0, 2'd0, 5'd7, 8'h00, 4, 1'b1, 8'h11, 1'b0);

    // P2 write miss of 6 with P1 aborting: write-back then response, not shared.
    set_snoop(3'b010, 3'b000, {8'h00, 8'h77, 8'h00});
    push_wr(5'd6, 8'h77);
    single(2, 2'd1, 5'd6, 8'h00, 3, 1'b1, 8'h77, 1'b0);

    // P1 clean write miss of 4 (leaves rr_ptr at 2).
    single(1, 2'd1, 5'd4, 8'h00, 2, 1'b0, 8'h00, 1'b0);

    // P0 read of 2, reset in its MEMR cycle: everything clears, no done.
    @(negedge clock);
    c = cyc;
    set_req(0, 2'd0, 5'd2, 8'h00);
    push_bus(2'd0, 5'd2, 0, c + 1);
    repeat (2) @(negedge clock);
    chk("memr_addr_before_reset", int'(bus_if.mem_addr), 2);
    reset = 1'b1;
    bus_if.req = '0;
    #1;
    chk_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // P1 and P2 request together: rr_ptr back at 0 so P1 goes first.
    c = cyc;
    set_req(1, 2'd0, 5'd10, 8'h00);
    set_req(2, 2'd0, 5'd11, 8'h00);
    push_bus(2'd0, 5'd10, 1, c + 1); push_rsp(1, 1'b1, 8'h4A, 1'b0, c + 4);
    push_bus(2'd0, 5'd11, 2, c + 6); push_rsp(2, 1'b1, 8'h4B, 1'b0, c + 9);
    repeat (4) @(negedge clock);
    bus_if.req[1] = 1'b0;
    repeat (5) @(negedge clock);
    bus_if.req[2] = 1'b0;
    drain();

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/snoop_bus_controller.md
# snoop_bus_controller

Shared-bus controller for the MESI multiprocessor. It sits between the per-processor cache/MESI controllers and the 32×8 main memory. It arbitrates bus requests (read miss, write miss, invalidate, write back) round-robin and broadcasts the winning transaction to all other processors' snoopers. It services snooper aborts with a write-back to memory, fetches memory data for read misses, and returns the data plus a shared flag to the requester.

## Interface
Parameters:
- N_PROC, 3: number of processors on the bus (2..4)
- ADDR_W, 5: address width
- DATA_W, 8: data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  N_PROC  per-processor bus request, held until matching done
- req_op  in  2*N_PROC  per-processor command; 0 read miss, 1 write miss, 2 invalidate, 3 write back
- req_addr  in  ADDR_W*N_PROC  per-processor address
- req_data  in  DATA_W*N_PROC  per-processor data (used for write back)
- gnt  out  N_PROC  one-hot grant, high from SNOOP through RESP
- done  out  N_PROC  one-hot completion pulse, 1 cycle
- bus_valid  out  1  snoop broadcast strobe, 1 cycle
- bus_op  out  2  broadcast command
- bus_addr  out  ADDR_W  broadcast address
- bus_src  out  2  index of the granted processor
- snoop_abort  in  N_PROC  snooper holds the line in M or E and supplies data
- snoop_shared  in  N_PROC  snooper holds a valid copy
- snoop_wb_data  in  DATA_W*N_PROC  snooper's copy of the line
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address sampled
- rsp_data  out  DATA_W  line data for the requester, valid with done
- rsp_shared  out  1  1: requester installs S; 0: installs E (read miss only)

## Operation
- All outputs are registered. On reset, every output is 0, the FSM is in IDLE, and the round-robin pointer is 0, so processor 0 has top priority first.
- IDLE: if any req bit is set, grant the first requester at or after rr_ptr, wrapping modulo N_PROC. Latch op, addr, data and src. Next state is SNOOP.
- SNOOP: gnt[src]=1, bus_valid=1, and bus_op/addr/src are driven. Sample snoop_abort and snoop_shared in this cycle. The requester's own bits are masked.
- Transitions from SNOOP:
  - op RD/WM with any abort → WB.
  - op RD without abort → MEMR.
  - op WM without abort → RESP.
  - op INV → RESP; abort is ignored.
  - op WB → MEMW.
- WB: mem_we=1, mem_addr=addr, mem_wdata=snoop_wb_data of the lowest-index aborting snooper. The same data is captured into rsp_data. Next state is RESP.
- MEMR: mem_we=0, mem_addr=addr. Next state is MEMD.
- MEMD: capture mem_rdata into rsp_data. Next state is RESP.
- MEMW: mem_we=1, mem_wdata=latched req_data. Next state is RESP.
- RESP: done[src]=1 and rsp_data valid. rsp_shared = (any masked shared or abort) for RD, else 0. Set rr_ptr=(src+1) mod N_PROC. Next state is IDLE, and gnt drops.
- mem_we is high only in WB and MEMW, for exactly 1 cycle per transaction.
- The requester deasserts req in the cycle after done. A req still high in IDLE is treated as a new request.

## Timing
- Take cycle 0 as the IDLE cycle in which req is sampled high. done is asserted in:
  - cycle 4 for RD without abort
  - cycle 3 for RD/WM with abort, and for WB
  - cycle 2 for WM without abort, and for INV
- bus_valid is asserted in cycle 1 only. There is one transaction on the bus at a time, with no overlap.
- Requests arriving during a transaction wait; they are evaluated in the first IDLE cycle after RESP.
- Minimum spacing between back-to-back grants is 1 IDLE cycle.
- Simultaneous aborts from several snoopers are a protocol violation. The lowest index supplies the data deterministically.
- Reset asserted mid-transaction returns the FSM to IDLE immediately and clears gnt, done, bus_valid and mem_we. A pending memory write is not issued unless the clock edge occurs before reset asserts.
- Changes to req_op/addr/data after grant are ignored; the values are latched in IDLE.

## Test plan
- Reset, then P1 RD addr 5 (memory[5]=0x3C, no snoop response) → bus_valid in cycle 1 with bus_op=0, bus_addr=5, bus_src=1; done[1] in cycle 4; rsp_data=0x3C; rsp_shared=0; mem_we never high.
- P0 RD addr 9; P2 asserts snoop_abort with wb_data 0xA5 → mem_we=1 in cycle 2 with addr 9, wdata 0xA5; done[0] in cycle 3; rsp_data=0xA5; rsp_shared=1; a later read of memory[9] returns 0xA5.
- P0, P1 and P2 request RD simultaneously from reset, with all req held → grants in order 0, 1, 2, then 0 again; each done precedes the next gnt; exactly one gnt bit is high at any time.
- P2 INV addr 3 while P0 asserts snoop_shared and snoop_abort → done[2] in cycle 2; mem_we stays 0.
- P1 WB addr 7 data 0x11 → mem_we=1 in cycle 2 with wdata 0x11; done[1] in cycle 3. Also: requester P0 asserting its own snoop_abort on its RD is masked, so no WB state.
- Reset asserted in the MEMR cycle of a P0 RD → all outputs 0 asynchronously; no done; a new P1 request after reset is granted first-come, with rr_ptr reset to 0.
